// File: rtl/jt89_pkg.sv
// jt89_pkg: shared types and helpers for the jt89 write scheduler
package jt89_pkg;

  typedef enum logic [1:0] {IDLE, LOW, GAP} seq_e;

  localparam logic [7:0] TONE_LATCH_MASK = 8'h90;

  function automatic logic is_tone_latch(input logic [7:0] b);
    return ((b & TONE_LATCH_MASK) == 8'h80) && (b[6:5] != 2'b11);
  endfunction

endpackage

// File: rtl/jt89_wr_fifo.sv
// jt89_wr_fifo: synchronous byte FIFO with occupancy count
module jt89_wr_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [7:0]   din,
  input  logic         pop,
  output logic [7:0]   dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;

  assign dout  = mem[rp];
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;

  // storage array, written on push only
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;

  // pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= push ? wp + AW'(1) : wp;
      rp    <= pop ? rp + AW'(1) : rp;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end

endmodule

// File: rtl/jt89_wr_sched.sv
// jt89_wr_sched: two-requester arbiter, tone-latch lock and paced wr_n replay for jt89
module jt89_wr_sched
  import jt89_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WR_LOW   = 2,
  parameter int WR_GAP   = 2,
  parameter int LOCK_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic [7:0]               din0,
  output logic                     ack0,
  input  logic                     req1,
  input  logic [7:0]               din1,
  output logic                     ack1,
  output logic                     psg_wr_n,
  output logic [7:0]               psg_din,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int SW  = $clog2((WR_LOW > WR_GAP ? WR_LOW : WR_GAP) + 1);
  localparam int LCW = $clog2(LOCK_CYC + 1);

  logic           e0, e1, g0, g1, push, pop, full, empty;
  logic           prio, locked, owner;
  logic [7:0]     gdin, fdout;
  logic [LCW-1:0] lcnt;
  logic [SW-1:0]  cnt, nxt_cnt;
  logic [LW-1:0]  nxt_level;
  seq_e           state, nxt_state;

  // a pending ack blocks re-acceptance; a lock shuts out the non-owner
  assign e0        = req0 & ~ack0 & ~full & (~locked | ~owner);
  assign e1        = req1 & ~ack1 & ~full & (~locked | owner);
  assign g0        = e0 & (~e1 | ~prio);
  assign g1        = e1 & (~e0 | prio);
  assign push      = g0 | g1;
  assign gdin      = g1 ? din1 : din0;
  assign nxt_level = level + LW'(push) - LW'(pop);

  jt89_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (gdin),
    .pop   (pop),
    .dout  (fdout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // acks, round-robin priority (1 = requester 1 preferred) and tone-latch lock
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      prio   <= 1'b0;
      locked <= 1'b0;
      owner  <= 1'b0;
      lcnt   <= '0;
    end else begin
      ack0 <= g0;
      ack1 <= g1;
      prio <= push ? g0 : prio;
      if (push && is_tone_latch(gdin)) begin
        locked <= 1'b1;
        owner  <= g1;
        lcnt   <= LCW'(LOCK_CYC);
      end else if (locked) begin
        locked <= ~(push | (lcnt == LCW'(1)));
        lcnt   <= lcnt - LCW'(1);
      end
    end

  // sequencer next state: pop from IDLE or at the end of GAP, then hold LOW/GAP
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        nxt_state = LOW;
        nxt_cnt   = SW'(WR_LOW - 1);
      end
      LOW: if (cnt == '0) begin
        nxt_state = GAP;
        nxt_cnt   = SW'(WR_GAP - 1);
      end else nxt_cnt = cnt - SW'(1);
      GAP: if (cnt != '0) nxt_cnt = cnt - SW'(1);
      else if (!empty) begin
        pop       = 1'b1;
        nxt_state = LOW;
        nxt_cnt   = SW'(WR_LOW - 1);
      end else nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // sequencer registers; wr_n and busy are registered from next-state values
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      psg_wr_n <= 1'b1;
      psg_din  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      psg_wr_n <= nxt_state != LOW;
      psg_din  <= pop ? fdout : psg_din;
      busy     <= (nxt_level != '0) | (nxt_state != IDLE);
    end

endmodule
